// File: rtl/fw_wishbone_sram_arb_2x1.sv
// Two-initiator Wishbone arbiter in front of the single-port SRAM controller.
// Round-robin grant. The grant is held for the owner's whole bus cycle (cyc high),
// so locked sequences and AMO read-modify-writes stay indivisible at the controller.
// Address, data, selects, we and tgc pass through untouched. ack, err and read data
// go back only to the current owner.
//
// state | meaning
// IDLE  | no owner; arbitrate on t0_cyc / t1_cyc, nothing driven downstream
// OWN0  | initiator 0 owns the controller port until t0_cyc drops
// OWN1  | initiator 1 owns the controller port until t1_cyc drops
module fw_wishbone_sram_arb_2x1 #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TGC_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic [ADR_WIDTH-1:0]   t0_adr,
  input  logic [DAT_WIDTH-1:0]   t0_dat_w,
  output logic [DAT_WIDTH-1:0]   t0_dat_r,
  input  logic                   t0_cyc,
  input  logic                   t0_stb,
  input  logic                   t0_we,
  input  logic [DAT_WIDTH/8-1:0] t0_sel,
  input  logic [TGC_WIDTH-1:0]   t0_tgc,
  output logic                   t0_ack,
  output logic                   t0_err,

  input  logic [ADR_WIDTH-1:0]   t1_adr,
  input  logic [DAT_WIDTH-1:0]   t1_dat_w,
  output logic [DAT_WIDTH-1:0]   t1_dat_r,
  input  logic                   t1_cyc,
  input  logic                   t1_stb,
  input  logic                   t1_we,
  input  logic [DAT_WIDTH/8-1:0] t1_sel,
  input  logic [TGC_WIDTH-1:0]   t1_tgc,
  output logic                   t1_ack,
  output logic                   t1_err,

  output logic [ADR_WIDTH-1:0]   i_adr,
  output logic [DAT_WIDTH-1:0]   i_dat_w,
  input  logic [DAT_WIDTH-1:0]   i_dat_r,
  output logic                   i_cyc,
  output logic                   i_stb,
  output logic                   i_we,
  output logic [DAT_WIDTH/8-1:0] i_sel,
  output logic [TGC_WIDTH-1:0]   i_tgc,
  input  logic                   i_ack,
  input  logic                   i_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  // 0 = port 0 was granted last, 1 = port 1. Resets to 1 so port 0 wins the first tie.
  logic   r_last_grant;
  logic   w_last_grant_nxt;

  // State and last-grant registers; async reset forces IDLE, which zeroes every output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state: round-robin on a tie, hold until the owner drops cyc, always pass through IDLE.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (t0_cyc && (!t1_cyc || r_last_grant)) begin
          w_state_nxt      = OWN0;
          w_last_grant_nxt = 1'b0;
        end else if (t1_cyc) begin
          w_state_nxt      = OWN1;
          w_last_grant_nxt = 1'b1;
        end
      end
      OWN0: begin
        if (!t0_cyc) begin
          w_state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (!t1_cyc) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output mux: owner's request straight to the controller, controller response only to the owner.
  // stb is qualified by cyc so a stray strobe, or the release cycle, never reaches the controller.
  always_comb begin
    i_cyc    = 1'b0;
    i_stb    = 1'b0;
    i_we     = 1'b0;
    i_adr    = '0;
    i_dat_w  = '0;
    i_sel    = '0;
    i_tgc    = '0;
    t0_ack   = 1'b0;
    t0_err   = 1'b0;
    t0_dat_r = '0;
    t1_ack   = 1'b0;
    t1_err   = 1'b0;
    t1_dat_r = '0;
    case (r_state)
      OWN0: begin
        i_cyc    = t0_cyc;
        i_stb    = t0_cyc & t0_stb;
        i_we     = t0_we;
        i_adr    = t0_adr;
        i_dat_w  = t0_dat_w;
        i_sel    = t0_sel;
        i_tgc    = t0_tgc;
        t0_ack   = i_ack;
        t0_err   = i_err;
        t0_dat_r = i_dat_r;
      end
      OWN1: begin
        i_cyc    = t1_cyc;
        i_stb    = t1_cyc & t1_stb;
        i_we     = t1_we;
        i_adr    = t1_adr;
        i_dat_w  = t1_dat_w;
        i_sel    = t1_sel;
        i_tgc    = t1_tgc;
        t1_ack   = i_ack;
        t1_err   = i_err;
        t1_dat_r = i_dat_r;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fw_wishbone_sram_arb_2x1.sv
// Bench for the 2x1 Wishbone arbiter: a small SRAM/AMO controller model answers the
// downstream port, initiator tasks push expected responses into per-port queues, and a
// negedge monitor pops them and checks grant order, pass-through and response routing.
// Port 0 uses byte addresses 0x000-0x0FC, port 1 uses 0x100-0x1FC; word 63 of each
// region answers with err.
`timescale 1ns/1ps
module tb_fw_wishbone_sram_arb_2x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int SW = DW / 8;
  localparam logic [TW-1:0] WB_AMO_ADD  = 4'd1;
  localparam logic [TW-1:0] WB_AMO_SWAP = 4'd2;

  logic clock = 1'b0;
  logic reset;

  logic [AW-1:0] t0_adr, t1_adr;
  logic [DW-1:0] t0_dat_w, t1_dat_w;
  logic [DW-1:0] t0_dat_r, t1_dat_r;
  logic          t0_cyc, t0_stb, t0_we, t1_cyc, t1_stb, t1_we;
  logic [SW-1:0] t0_sel, t1_sel;
  logic [TW-1:0] t0_tgc, t1_tgc;
  logic          t0_ack, t0_err, t1_ack, t1_err;

  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat_w, i_dat_r;
  logic          i_cyc, i_stb, i_we, i_ack, i_err;
  logic [SW-1:0] i_sel;
  logic [TW-1:0] i_tgc;

  logic          m_ack, m_err, stray_ack, stray_err;
  logic [DW-1:0] m_dat;
  logic [DW-1:0] m_mem [128];
  logic [DW-1:0] ref_mem [128];

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  fw_wishbone_sram_arb_2x1 #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TGC_WIDTH(TW)) dut (
    .clock(clock), .reset(reset),
    .t0_adr(t0_adr), .t0_dat_w(t0_dat_w), .t0_dat_r(t0_dat_r), .t0_cyc(t0_cyc),
    .t0_stb(t0_stb), .t0_we(t0_we), .t0_sel(t0_sel), .t0_tgc(t0_tgc),
    .t0_ack(t0_ack), .t0_err(t0_err),
    .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_dat_r(t1_dat_r), .t1_cyc(t1_cyc),
    .t1_stb(t1_stb), .t1_we(t1_we), .t1_sel(t1_sel), .t1_tgc(t1_tgc),
    .t1_ack(t1_ack), .t1_err(t1_err),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_cyc(i_cyc),
    .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_tgc(i_tgc),
    .i_ack(i_ack), .i_err(i_err)
  );

  function automatic logic [DW-1:0] init_val(input int w);
    if (w == 4)  return 32'hDEAD_BEEF;
    if (w == 68) return 32'd3;
    return 32'h1357_0000 ^ (32'(w) * 32'h0101_0011);
  endfunction

  function automatic logic [DW-1:0] apply_op(input logic [DW-1:0] old, input logic [DW-1:0] dat,
                                             input logic [SW-1:0] sel, input logic we,
                                             input logic [TW-1:0] tgc);
    logic [DW-1:0] r;
    r = old;
    if (tgc == WB_AMO_ADD) r = old + dat;
    else if (tgc == WB_AMO_SWAP) r = dat;
    else if (we) begin
      for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    end
    return r;
  endfunction

  // SRAM controller model: one registered ack/err per strobe, returns the pre-op word.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      m_dat <= '0;
      for (int i = 0; i < 128; i++) m_mem[i] <= init_val(i);
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (i_cyc && i_stb && !m_ack && !m_err) begin
        if (i_adr[7:2] == 6'h3F) begin
          m_err <= 1'b1;
          m_dat <= '0;
        end else begin
          m_ack <= 1'b1;
          m_dat <= m_mem[i_adr[8:2]];
          m_mem[i_adr[8:2]] <= apply_op(m_mem[i_adr[8:2]], i_dat_w, i_sel, i_we, i_tgc);
        end
      end
    end
  end

  assign i_ack   = (m_ack & i_cyc & i_stb) | stray_ack;
  assign i_err   = (m_err & i_cyc & i_stb) | stray_err;
  assign i_dat_r = m_dat;

  task automatic ref_init();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic set_cs(input int p, input logic cyc, input logic stb);
    if (p == 0) begin t0_cyc = cyc; t0_stb = stb; end
    else        begin t1_cyc = cyc; t1_stb = stb; end
  endtask

  task automatic set_fields(input int p, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                            input logic [TW-1:0] tgc);
    if (p == 0) begin t0_we = we; t0_adr = adr; t0_dat_w = dat; t0_sel = sel; t0_tgc = tgc; end
    else        begin t1_we = we; t1_adr = adr; t1_dat_w = dat; t1_sel = sel; t1_tgc = tgc; end
  endtask

  // One strobe/ack beat inside an open (or opening) cycle; called just after a posedge.
  task automatic beat(input int p, input logic we, input int word, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic [TW-1:0] tgc);
    int   w;
    int   guard;
    bit   done;
    exp_t e;
    w     = p * 64 + (word % 64);
    e.err = ((word % 64) == 63);
    e.dat = e.err ? 32'h0 : ref_mem[w];
    if (!e.err) ref_mem[w] = apply_op(ref_mem[w], dat, sel, we, tgc);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    set_fields(p, we, 32'(w) << 2, dat, sel, tgc);
    set_cs(p, 1'b1, 1'b1);
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clock);
      guard++;
      done = (p == 0) ? (t0_ack | t0_err) : (t1_ack | t1_err);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL ack_timeout port%0d: no ack/err seen, required one within 200 cycles", p);
    end
    @(posedge clock); #1;
    set_cs(p, 1'b1, 1'b0);
  endtask

  task automatic close_cyc(input int p);
    set_cs(p, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_beat(input int p);
    logic [TW-1:0] tgc;
    logic          we;
    logic [SW-1:0] sel;
    int            r;
    r   = $urandom_range(0, 5);
    tgc = (r == 0) ? WB_AMO_ADD : (r == 1) ? WB_AMO_SWAP : 4'd0;
    we  = (tgc != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    sel = (tgc != 0) ? 4'hF : 4'($urandom_range(0, 15));
    beat(p, we, $urandom_range(0, 63), $urandom, sel, tgc);
  endtask

  task automatic single(input int p, input int word);
    beat(p, 1'b0, word, 32'h0, 4'hF, 4'd0);
    close_cyc(p);
  endtask

  task automatic check_log2(input string name, input int a, input int b);
    total++;
    if (grant_log.size() < 2 || grant_log[0] != a || grant_log[1] != b) begin
      bad++;
      $display("FAIL %s: grant order size=%0d first=%0d second=%0d, required %0d then %0d", name,
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1,
               (grant_log.size() > 1) ? grant_log[1] : -1, a, b);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: responses against the queues, pass-through, grant order, latency and idle quiet.
  initial begin : monitor
    logic pc0, pc1;
    int   zr, last_owner, own, exp_own;
    bit   ok;
    exp_t e;
    pc0 = 1'b0; pc1 = 1'b0; zr = 2; last_owner = 1;
    forever begin
      @(negedge clock);
      if (!reset) begin
        total++;
        if ({i_cyc, i_stb, i_we, i_sel, i_tgc, i_adr, i_dat_w, t0_ack, t0_err, t0_dat_r,
             t1_ack, t1_err, t1_dat_r} !== '0) begin
          bad++;
          $display("FAIL reset_outputs: i_cyc=%0b i_adr=%08h t0_ack=%0b t1_ack=%0b, required all 0",
                   i_cyc, i_adr, t0_ack, t1_ack);
        end
        pc0 = 1'b0; pc1 = 1'b0; zr = 2; last_owner = 1;
      end else begin
        if (t0_ack | t0_err) begin
          total++;
          if (q0.size() == 0) begin
            bad++;
            $display("FAIL p0_unexpected: ack=%0b err=%0b, required no response", t0_ack, t0_err);
          end else begin
            e = q0.pop_front();
            if (t0_err !== e.err || t0_dat_r !== e.dat) begin
              bad++;
              $display("FAIL p0_response: err=%0b dat=%08h, required err=%0b dat=%08h",
                       t0_err, t0_dat_r, e.err, e.dat);
            end
          end
        end
        if (t1_ack | t1_err) begin
          total++;
          if (q1.size() == 0) begin
            bad++;
            $display("FAIL p1_unexpected: ack=%0b err=%0b, required no response", t1_ack, t1_err);
          end else begin
            e = q1.pop_front();
            if (t1_err !== e.err || t1_dat_r !== e.dat) begin
              bad++;
              $display("FAIL p1_response: err=%0b dat=%08h, required err=%0b dat=%08h",
                       t1_err, t1_dat_r, e.err, e.dat);
            end
          end
        end
        if (i_cyc === 1'b1) begin
          own = int'(i_adr[8]);
          if (own == 0)
            ok = t0_cyc && i_stb === t0_stb && i_we === t0_we && i_adr === t0_adr &&
                 i_dat_w === t0_dat_w && i_sel === t0_sel && i_tgc === t0_tgc &&
                 t0_ack === i_ack && t0_err === i_err && t0_dat_r === i_dat_r &&
                 !t1_ack && !t1_err && t1_dat_r === '0;
          else
            ok = t1_cyc && i_stb === t1_stb && i_we === t1_we && i_adr === t1_adr &&
                 i_dat_w === t1_dat_w && i_sel === t1_sel && i_tgc === t1_tgc &&
                 t1_ack === i_ack && t1_err === i_err && t1_dat_r === i_dat_r &&
                 !t0_ack && !t0_err && t0_dat_r === '0;
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL pass_through: owner=%0d i_adr=%08h i_tgc=%0h i_dat_w=%08h, required owner's signals",
                     own, i_adr, i_tgc, i_dat_w);
          end
          if (zr > 0) begin
            exp_own = (pc0 && pc1) ? 1 - last_owner : (pc0 ? 0 : 1);
            total++;
            if (zr < 2 || !(pc0 || pc1) || own != exp_own) begin
              bad++;
              $display("FAIL grant: port=%0d idle_gap=%0d, required port=%0d after >=2 idle samples",
                       own, zr, exp_own);
            end
            last_owner = own;
            grant_log.push_back(own);
          end
        end else begin
          if (zr >= 2 && (pc0 || pc1)) begin
            total++;
            bad++;
            $display("FAIL grant_latency: i_cyc=0, required 1 one cycle after request in idle");
          end
          if (zr >= 1) begin
            total++;
            if ({i_stb, i_we, i_sel, i_tgc, i_adr, i_dat_w, t0_ack, t0_err, t0_dat_r,
                 t1_ack, t1_err, t1_dat_r} !== '0) begin
              bad++;
              $display("FAIL idle_quiet: i_stb=%0b i_adr=%08h t0_ack=%0b t1_ack=%0b t0_err=%0b t1_err=%0b, required all 0",
                       i_stb, i_adr, t0_ack, t1_ack, t0_err, t1_err);
            end
          end else begin
            total++;
            if (i_stb !== 1'b0) begin
              bad++;
              $display("FAIL release_stb: i_stb=%0b with i_cyc=0, required 0", i_stb);
            end
          end
        end
        pc0 = t0_cyc;
        pc1 = t1_cyc;
        zr  = (i_cyc === 1'b1) ? 0 : ((zr < 10) ? zr + 1 : zr);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int guard;
    reset = 1'b0;
    stray_ack = 1'b0; stray_err = 1'b0;
    t0_cyc = 1'b0; t0_stb = 1'b0; t1_cyc = 1'b0; t1_stb = 1'b0;
    set_fields(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 4'h0);
    set_fields(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 4'h0);
    ref_init();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Tie straight after reset: port 0 first, then port 1 after the idle gap.
    grant_log.delete();
    fork
      single(0, 1);
      single(1, 2);
    join
    check_log2("tie_after_reset", 0, 1);
    idle_cycles(3);

    // Single read on port 0 from 0x10: grant one cycle after cyc, data DEADBEEF.
    fork
      single(0, 4);
      begin
        @(negedge clock);
        total++;
        if (i_cyc !== 1'b0) begin
          bad++;
          $display("FAIL idle_no_drive: i_cyc=%0b in request cycle, required 0", i_cyc);
        end
        @(negedge clock);
        total++;
        if (i_cyc !== 1'b1 || i_adr !== 32'h10) begin
          bad++;
          $display("FAIL first_grant: i_cyc=%0b i_adr=%08h, required 1 and 00000010", i_cyc, i_adr);
        end
      end
    join
    idle_cycles(3);

    // Stray ack/err while idle and strobe without cycle: nothing may come back or be granted.
    t0_stb = 1'b1;
    stray_ack = 1'b1; stray_err = 1'b1;
    repeat (3) begin
      @(negedge clock);
      total++;
      if ({t0_ack, t0_err, t1_ack, t1_err, i_cyc} !== 5'b0) begin
        bad++;
        $display("FAIL stray_inputs: t0_ack=%0b t0_err=%0b t1_ack=%0b t1_err=%0b i_cyc=%0b, required all 0",
                 t0_ack, t0_err, t1_ack, t1_err, i_cyc);
      end
    end
    @(posedge clock); #1;
    stray_ack = 1'b0; stray_err = 1'b0; t0_stb = 1'b0;
    idle_cycles(2);

    // AMO add on port 1 (3 + 5), then read back 8; port 0 waits for t1 to drop cyc.
    grant_log.delete();
    fork
      begin
        beat(1, 1'b1, 4, 32'd5, 4'hF, WB_AMO_ADD);
        close_cyc(1);
        idle_cycles(1);
        single(1, 4);
      end
      begin
        idle_cycles(1);
        single(0, 5);
      end
    join
    check_log2("amo_hold_off", 1, 0);
    total++;
    if (ref_mem[68] !== 32'd8) begin
      bad++;
      $display("FAIL amo_model: word=%0d, required 8", ref_mem[68]);
    end
    idle_cycles(3);

    // Locked burst: three beats on port 0 while port 1 waits.
    grant_log.delete();
    fork
      begin
        rand_beat(0); rand_beat(0); rand_beat(0);
        close_cyc(0);
      end
      begin
        idle_cycles(2);
        single(1, 9);
      end
    join
    check_log2("locked_burst", 0, 1);
    idle_cycles(3);

    // Round robin: both ports request continuously, four transactions each.
    grant_log.delete();
    fork
      repeat (4) begin rand_beat(0); close_cyc(0); idle_cycles(1); end
      repeat (4) begin rand_beat(1); close_cyc(1); idle_cycles(1); end
    join
    total++;
    if (grant_log.size() != 8) begin
      bad++;
      $display("FAIL rr_count: grants=%0d, required 8", grant_log.size());
    end
    for (int i = 1; i < grant_log.size(); i++) begin
      total++;
      if (grant_log[i] == grant_log[i-1]) begin
        bad++;
        $display("FAIL rr_alternate: grant %0d port=%0d same as previous, required other port",
                 i, grant_log[i]);
      end
    end
    idle_cycles(3);

    // Random traffic on both ports.
    fork
      repeat (12) begin
        repeat ($urandom_range(1, 3)) rand_beat(0);
        close_cyc(0);
        idle_cycles($urandom_range(1, 4));
      end
      repeat (12) begin
        repeat ($urandom_range(1, 3)) rand_beat(1);
        close_cyc(1);
        idle_cycles($urandom_range(1, 4));
      end
    join
    idle_cycles(3);

    // Reset while port 1 owns the controller mid-AMO.
    set_fields(1, 1'b1, 32'h0000_0110, 32'd7, 4'hF, WB_AMO_ADD);
    set_cs(1, 1'b1, 1'b1);
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (i_cyc !== 1'b1 && guard < 20);
    total++;
    if (i_cyc !== 1'b1) begin
      bad++;
      $display("FAIL reset_setup: i_cyc=%0b, required port 1 granted", i_cyc);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({i_cyc, i_stb, i_we, i_sel, i_tgc, i_adr, i_dat_w, t0_ack, t0_err, t0_dat_r,
         t1_ack, t1_err, t1_dat_r} !== '0) begin
      bad++;
      $display("FAIL async_reset: i_cyc=%0b i_tgc=%0h i_adr=%08h, required all 0", i_cyc, i_tgc, i_adr);
    end
    set_cs(1, 1'b0, 1'b0);
    q0.delete();
    q1.delete();
    ref_init();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    grant_log.delete();
    fork
      single(0, 10);
      single(1, 11);
    join
    check_log2("tie_after_mid_reset", 0, 1);
    idle_cycles(5);

    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover: q0=%0d q1=%0d outstanding, required 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fw_wishbone_sram_arb_2x1.md
Name: fw_wishbone_sram_arb_2x1

Overview:
Two-initiator Wishbone arbiter placed directly upstream of the single-port Wishbone SRAM controller. It feeds that controller's target port.
Round-robin grant; the grant is held for the owner's whole bus cycle, as long as cyc stays high.
Address, data, byte selects, we and the AMO cycle tag (tgc) pass through unmodified, so atomic operations stay indivisible at the controller.
ack and read data are routed back only to the current owner.

Parameters:
ADR_WIDTH, 32, Wishbone byte-address width
DAT_WIDTH, 32, data width; multiple of 8
TGC_WIDTH, 4, cycle-tag width (AMO opcode; 0 = plain access)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
t0_adr  in  ADR_WIDTH  initiator 0 address
t0_dat_w  in  DAT_WIDTH  initiator 0 write data
t0_dat_r  out  DAT_WIDTH  initiator 0 read data
t0_cyc  in  1  initiator 0 cycle
t0_stb  in  1  initiator 0 strobe
t0_we  in  1  initiator 0 write enable
t0_sel  in  DAT_WIDTH/8  initiator 0 byte selects
t0_tgc  in  TGC_WIDTH  initiator 0 cycle tag (AMO op)
t0_ack  out  1  initiator 0 acknowledge
t0_err  out  1  initiator 0 error
t1_*  same set as t0_*, for initiator 1
i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel, i_tgc  out  as above  to SRAM controller target port
i_dat_r  in  DAT_WIDTH  controller read data
i_ack  in  1  controller acknowledge
i_err  in  1  controller error

Behaviour:
- State register values: IDLE, OWN0, OWN1. A 1-bit last_grant register holds the last granted port.
- Reset (reset==0, async):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All outputs 0: i_cyc, i_stb, i_we, i_sel, i_tgc, i_adr, i_dat_w, t*_ack, t*_err, t*_dat_r.
- Arbitration, IDLE, evaluated each cycle on the t*_cyc inputs:
  - Only t0_cyc high -> next OWN0.
  - Only t1_cyc high -> next OWN1.
  - Both high -> grant the port != last_grant.
  - On the grant edge, last_grant <= granted port.
  - Grant latency is 1 cycle: no i_ signal is driven in IDLE.
- Ownership, OWNn:
  - i_* = tn_* combinationally.
  - tn_ack = i_ack, tn_err = i_err, tn_dat_r = i_dat_r.
  - The non-owner sees ack=0, err=0, dat_r=0.
- Release:
  - When the owner's cyc is sampled low in OWNn, next state is IDLE. i_cyc and i_stb drop that same cycle, combinationally from tn_cyc.
  - Minimum one IDLE cycle between owners. This guarantees the controller sees cyc low and returns to its idle state.
  - The owner may keep cyc high across multiple stb/ack beats (locked sequence). No preemption.
- Tags: i_tgc passes through unchanged. A non-zero tgc (AMO) is acked by the controller after its read-modify-write. The arbiter does not interpret tgc.
- Simultaneous events:
  - Owner drops cyc while the other requests -> IDLE for 1 cycle, then grant to the other port (it != last_grant).
  - Owner drops cyc and re-raises it in the next IDLE cycle while the other port is also requesting -> the other port wins.
- Stray inputs:
  - i_ack or i_err while IDLE is ignored; no t*_ack or t*_err is produced.
  - tn_stb without tn_cyc is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The in-flight controller access is abandoned; the controller is reset by the same reset.

Test Plan:
- Single read, port 0: t0 cyc/stb, adr=0x10, tgc=0; controller returns dat_r=0xDEADBEEF.
  -> i_cyc rises 1 cycle after t0_cyc; t0_ack pulses with t0_dat_r=0xDEADBEEF; t1_ack stays 0.
- Tie after reset: t0 and t1 both raise cyc in the same cycle.
  -> port 0 granted first; after t0 drops cyc, one IDLE cycle, then port 1 granted with i_adr = t1_adr.
- Round-robin: both ports request continuously, 4 transactions each.
  -> grants alternate 0,1,0,1,...; neither port is granted twice in a row.
- AMO pass-through: t1 sends tgc=WB_AMO_ADD, dat_w=5 to a word holding 3.
  -> i_tgc=WB_AMO_ADD and i_dat_w=5 for the whole ownership; t1_dat_r=3 on ack; a subsequent read returns 8; t0 is held off until t1 drops cyc.
- Locked burst: t0 holds cyc for 3 stb/ack beats while t1 requests.
  -> t1 gets no ack until t0 drops cyc; t1 is then granted after the 1-cycle IDLE gap.
- Reset asserted in OWN1 mid-AMO.
  -> all outputs 0 asynchronously; after release, the first tie is granted to port 0.
